// File: rtl/cdc_handshake_rx_if.sv
// cdc_handshake_rx_if: toggle handshake bundle between a source
// domain, the receiver and its local consumer.
interface cdc_handshake_rx_if #(
  parameter int WIDTH = 8
);
  logic             req_toggle;
  logic [WIDTH-1:0] data_in;
  logic             ack_toggle;
  logic             rx_ready;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;

  modport master (
    output req_toggle,
    output data_in,
    output rx_ready,
    input  ack_toggle,
    input  data_out,
    input  data_valid
  );

  modport slave (
    input  req_toggle,
    input  data_in,
    input  rx_ready,
    output ack_toggle,
    output data_out,
    output data_valid
  );
endinterface

// File: rtl/cdc_handshake_rx.sv
// cdc_handshake_rx: receive side of a toggle req/ack clock crossing.
// Synchronizes req, captures data, holds it for the consumer, acks.
module cdc_handshake_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 3
) (
  input  logic                Bclk,
  input  logic                reset,
  cdc_handshake_rx_if.slave   bus,
  output logic                protocol_err,
  output logic [15:0]         xfer_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_e;

  state_e                 state_q;
  state_e                 state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_sync;
  logic                   req_seen_q;
  logic                   new_req;
  logic                   ack_q;
  logic [WIDTH-1:0]       data_q;
  logic                   valid_q;
  logic                   err_q;
  logic [15:0]            cnt_q;
  logic                   capture;
  logic                   consume;
  logic                   viol;

  // Only this chain samples the asynchronous req_toggle.
  always_ff @(posedge Bclk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req_toggle};
    end
  end

  assign req_sync = sync_q[SYNC_STAGES-1];
  assign new_req  = req_sync ^ req_seen_q;

  // State register.
  always_ff @(posedge Bclk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a request arriving while a word is held is an error
  // and stays pending until the state returns to IDLE.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    consume = 1'b0;
    viol    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (new_req) begin
          capture = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        viol = new_req;
        if (bus.rx_ready) begin
          consume = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture, ack, count and sticky error registers.
  always_ff @(posedge Bclk or negedge reset) begin
    if (!reset) begin
      req_seen_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ack_q      <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= (state_d == VALID);
      if (capture) begin
        req_seen_q <= req_sync;
        data_q     <= bus.data_in;
      end
      if (consume) begin
        ack_q <= ~ack_q;
        cnt_q <= cnt_q + 16'd1;
      end
      if (viol) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.ack_toggle = ack_q;
  assign protocol_err   = err_q;
  assign xfer_count     = cnt_q;

endmodule

// File: doc/cdc_handshake_rx.md
CDC_HANDSHAKE_RX -- requirements
Module: cdc_handshake_rx

Interface
REQ-001 Parameter WIDTH, default 8, data bus width in bits (1..64).
REQ-002 Parameter SYNC_STAGES, default 3, depth of the req synchronizer chain (2..4).
REQ-003 Bclk  input  1  sole clock; all state is updated on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
REQ-005 req_toggle  input  1  request toggle from the source clock domain, asynchronous to Bclk; each level change is one transfer request.
REQ-006 data_in  input  WIDTH  source data; source holds it stable from the req_toggle change until it sees ack_toggle change.
REQ-007 rx_ready  input  1  local consumer ready to accept data_out.
REQ-008 ack_toggle  output  1  acknowledge toggle returned to the source; changes once per completed transfer.
REQ-009 data_out  output  WIDTH  registered captured data.
REQ-010 data_valid  output  1  registered; data_out holds an unconsumed word.
REQ-011 protocol_err  output  1  sticky flag for a req_toggle change seen before ack_toggle was returned.
REQ-012 xfer_count  output  16  count of completed transfers.

Function
REQ-013 req_toggle SHALL pass through a chain of SYNC_STAGES flops clocked by Bclk; req_sync is the last stage; no other logic SHALL sample req_toggle directly.
REQ-014 Register req_seen SHALL hold the last accepted req_sync level; new_req = (req_sync != req_seen).
REQ-015 FSM states: IDLE, VALID.
REQ-016 In IDLE, when new_req=1: data_in SHALL be captured into data_out, req_seen SHALL be updated to req_sync, and the state SHALL become VALID, all on one edge.
REQ-017 data_valid SHALL be 1 exactly while the state is VALID.
REQ-018 Latency: a req_toggle change set up before Bclk edge 1 SHALL give data_valid=1 after edge SYNC_STAGES+1 (edge 4 at default).
REQ-019 In VALID, on an edge with rx_ready=1: ack_toggle SHALL invert, xfer_count SHALL increment, and the state SHALL return to IDLE.
REQ-020 In VALID with rx_ready=0, the state, data_out and ack_toggle SHALL hold for any number of cycles; ack to the source is thereby delayed.
REQ-021 data_out SHALL only change on a capture edge; it retains the last word after data_valid falls.
REQ-022 If new_req=1 while in VALID, protocol_err SHALL be set to 1 and req_seen SHALL NOT update; the pending request SHALL be accepted on the first IDLE cycle that follows.
REQ-023 protocol_err SHALL stay at 1 until reset.
REQ-024 xfer_count SHALL wrap from 16'hFFFF to 16'h0000 with no flag.
REQ-025 Minimum spacing: back-to-back transfers with rx_ready tied to 1 SHALL complete one per 2 Bclk cycles once req_sync has changed (capture edge, then ack edge).
REQ-026 The data path SHALL use no combinational path from any input to any output.

Reset
REQ-027 Under reset=0, all of the following SHALL be 0, asynchronously: the sync chain, req_seen, ack_toggle, data_out, data_valid, protocol_err, xfer_count; the state SHALL be IDLE.
REQ-028 If reset is asserted in VALID, the held word SHALL be discarded without an ack_toggle change; the source SHALL be reset with this block.
REQ-029 After reset release, the first request SHALL be the req_toggle transition 0->1.

Verification
REQ-030 Single transfer: reset release, data_in=8'hA5, req_toggle 0->1, rx_ready=1 -> data_valid=1 after edge 4 with data_out=8'hA5; ack_toggle=1 and xfer_count=1 after edge 5.
REQ-031 Backpressure: rx_ready=0 for 10 cycles after data_valid rises -> data_valid, data_out and ack_toggle unchanged for those cycles; ack toggles on the first edge with rx_ready=1.
REQ-032 Streaming: 20 toggle-handshake transfers with incrementing data from an independent clock at ratios 1:3, 1:1 and 3:1 -> all 20 words arrive in order, none dropped or duplicated, xfer_count=20, protocol_err=0.
REQ-033 Violation: toggle req_toggle a second time while data_valid=1 and rx_ready=0 -> protocol_err=1 (sticky); the second word is accepted after the first is consumed.
REQ-034 Reset mid-transfer: assert reset while data_valid=1 -> data_valid=0, ack_toggle=0, data_out=0 immediately, before any Bclk edge.
REQ-035 Wrap: preload xfer_count to 16'hFFFF (force), complete one transfer -> xfer_count=16'h0000.
